// File: rtl/fact_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fact_sched_pkg : shared types, register map and round-robin helper   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package fact_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_N    = 3'd1,
    ST_WR_GO   = 3'd2,
    ST_RD_RES  = 3'd3,
    ST_RD_STAT = 3'd4
  } state_t;

  localparam logic [1:0] FACT_REG_N    = 2'd0;
  localparam logic [1:0] FACT_REG_GO   = 2'd1;
  localparam logic [1:0] FACT_REG_STAT = 2'd2;
  localparam logic [1:0] FACT_REG_RES  = 2'd3;

  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_ERR_BIT  = 1;

  // First set bit of req at or after ptr, wrapping; returns ptr if req is empty.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : first-word-fall-through FIFO with occupancy count        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int c_PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && (r_count != (c_PTR_W+1)'(DEPTH));

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_valid = (r_count != '0);
  assign o_rdata = o_valid ? r_mem[r_rptr] : '0;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fact_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fact_sched : round-robin job dispatcher/collector for 4 fact units   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module fact_sched
  import fact_sched_pkg::*;
#(
  parameter int NUM_FACT  = 4,
  parameter int TAG_W     = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [3:0]        job_n,
  input  logic [TAG_W-1:0]  job_tag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic              res_err,
  output logic [TAG_W-1:0]  res_tag,
  output logic [3:0]        fact_we,
  output logic [7:0]        fact_addr,
  output logic [127:0]      fact_wdata,
  input  logic [127:0]      fact_rdata,
  input  logic [3:0]        fact_done,
  output logic [3:0]        busy
);
  localparam int c_ENTRY_W = TAG_W + 33;
  localparam int c_CNT_W   = $clog2(RES_DEPTH) + 1;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_unit;
  logic [1:0]          r_dptr;
  logic [1:0]          r_cptr;
  logic [3:0]          r_n;
  logic [TAG_W-1:0]    r_tag [NUM_FACT];
  logic [31:0]         r_result;
  logic [3:0]          r_busy;

  logic [3:0]          w_collect_req;
  logic                w_can_collect;
  logic                w_ready;
  logic                w_accept;
  logic [1:0]          w_disp_unit;
  logic                w_push;
  logic                w_drive;
  logic                w_we;
  logic [1:0]          w_addr;
  logic [31:0]         w_wdata;
  logic [31:0]         w_rdata_sel;
  logic [c_CNT_W-1:0]  w_fifo_count;
  logic [c_ENTRY_W-1:0] w_push_data;
  logic [c_ENTRY_W-1:0] w_head;

  assign w_collect_req = r_busy & fact_done;
  assign w_can_collect = (|w_collect_req) && (w_fifo_count < c_CNT_W'(RES_DEPTH));
  assign w_disp_unit   = rr_pick(~r_busy, r_dptr);
  assign w_rdata_sel   = fact_rdata[{r_unit, 5'd0} +: 32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_ready  = 1'b0;
    w_accept = 1'b0;
    w_drive  = 1'b0;
    w_we     = 1'b0;
    w_addr   = FACT_REG_N;
    w_wdata  = 32'd0;
    w_push   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Draining finished units first keeps units free for new work.
        if (w_can_collect) begin
          w_next = ST_RD_RES;
        end else begin
          w_ready = rst & (|(~r_busy));
          if (job_valid && w_ready) begin
            w_accept = 1'b1;
            w_next   = ST_WR_N;
          end
        end
      end
      ST_WR_N: begin
        w_drive = 1'b1;
        w_we    = 1'b1;
        w_addr  = FACT_REG_N;
        w_wdata = {28'd0, r_n};
        w_next  = ST_WR_GO;
      end
      ST_WR_GO: begin
        w_drive = 1'b1;
        w_we    = 1'b1;
        w_addr  = FACT_REG_GO;
        w_wdata = 32'd1;
        w_next  = ST_IDLE;
      end
      ST_RD_RES: begin
        w_drive = 1'b1;
        w_addr  = FACT_REG_RES;
        w_next  = ST_RD_STAT;
      end
      ST_RD_STAT: begin
        w_drive = 1'b1;
        w_addr  = FACT_REG_STAT;
        w_push  = 1'b1;
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_unit   <= 2'd0;
      r_n      <= 4'd0;
      r_result <= 32'd0;
      r_busy   <= 4'd0;
      r_dptr   <= 2'd0;
      r_cptr   <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_can_collect) begin
            r_unit <= rr_pick(w_collect_req, r_cptr);
          end else if (w_accept) begin
            r_unit <= w_disp_unit;
            r_n    <= job_n;
          end
        end
        ST_WR_GO: begin
          r_busy[r_unit] <= 1'b1;
          r_dptr         <= r_unit + 2'd1;
        end
        ST_RD_RES: r_result <= w_rdata_sel;
        ST_RD_STAT: begin
          r_busy[r_unit] <= 1'b0;
          r_cptr         <= r_unit + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FACT; i++) r_tag[i] <= '0;
    end else if (w_accept) begin
      r_tag[w_disp_unit] <= job_tag;
    end
  end

  for (genvar u = 0; u < NUM_FACT; u++) begin : g_unit
    logic w_sel;
    assign w_sel                  = w_drive && (r_unit == 2'(u));
    assign fact_we[u]             = w_sel & w_we;
    assign fact_addr[2*u +: 2]    = w_sel ? w_addr  : 2'b00;
    assign fact_wdata[32*u +: 32] = w_sel ? w_wdata : 32'd0;
  end

  assign w_push_data = {r_tag[r_unit], w_rdata_sel[STAT_ERR_BIT], r_result};

  sync_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (res_ready),
    .o_rdata (w_head),
    .o_valid (res_valid),
    .o_count (w_fifo_count)
  );

  assign {res_tag, res_err, res_data} = w_head;
  assign job_ready = w_ready;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fact_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fact_sched : self-checking bench with behavioural factorial units |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fact_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [3:0]   job_n = 4'd0;
  logic [3:0]   job_tag = 4'd0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [31:0]  res_data;
  logic         res_err;
  logic [3:0]   res_tag;
  logic [3:0]   fact_we;
  logic [7:0]   fact_addr;
  logic [127:0] fact_wdata;
  logic [127:0] fact_rdata;
  logic [3:0]   fact_done;
  logic [3:0]   busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fact_sched #(.NUM_FACT(4), .TAG_W(4), .RES_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_n(job_n), .job_tag(job_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .res_tag(res_tag),
    .fact_we(fact_we), .fact_addr(fact_addr), .fact_wdata(fact_wdata),
    .fact_rdata(fact_rdata), .fact_done(fact_done), .busy(busy)
  );

  function automatic logic [31:0] ref_fact(input logic [3:0] n);
    logic [31:0] p;
    p = 32'd1;
    if (n > 4'd12) return 32'd0;
    for (int k = 2; k <= int'(n); k++) p = p * 32'(k);
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Behavioural factorial units: done drops on GO and rises u_lat cycles later.
  logic [3:0] u_n [4];
  logic [3:0] u_done;
  int         u_cnt [4];
  int         u_lat [4];

  assign fact_done = u_done;

  always @(posedge clk) begin
    for (int u = 0; u < 4; u++) begin
      if (fact_we[u] && fact_addr[2*u +: 2] == 2'd0) u_n[u] <= fact_wdata[32*u +: 4];
      if (fact_we[u] && fact_addr[2*u +: 2] == 2'd1) begin
        u_done[u] <= 1'b0;
        u_cnt[u]  <= u_lat[u];
      end else if (u_cnt[u] > 0) begin
        u_cnt[u] <= u_cnt[u] - 1;
        if (u_cnt[u] == 1) u_done[u] <= 1'b1;
      end
    end
  end

  always_comb begin
    fact_rdata = '0;
    for (int u = 0; u < 4; u++) begin
      case (fact_addr[2*u +: 2])
        2'd2:    fact_rdata[32*u +: 32] = {30'd0, (u_n[u] > 4'd12), u_done[u]};
        2'd3:    fact_rdata[32*u +: 32] = ref_fact(u_n[u]);
        default: ;
      endcase
    end
  end

  // Scoreboard keyed by tag: every accepted job must come back exactly once.
  logic [31:0] exp_val  [16];
  logic        exp_err  [16];
  logic        exp_pend [16];

  always @(negedge clk) begin
    if (!rst) begin
      for (int t = 0; t < 16; t++) exp_pend[t] = 1'b0;
    end else begin
      if (fact_we != 4'd0) check("we_onehot", 64'($onehot(fact_we)), 64'd1);
      if (job_valid && job_ready) begin
        exp_val[job_tag]  = ref_fact(job_n);
        exp_err[job_tag]  = (job_n > 4'd12);
        exp_pend[job_tag] = 1'b1;
      end
      if (res_valid && res_ready) begin
        check("pop_pending", 64'(exp_pend[res_tag]), 64'd1);
        check("pop_data", 64'(res_data), 64'(exp_val[res_tag]));
        check("pop_err", 64'(res_err), 64'(exp_err[res_tag]));
        exp_pend[res_tag] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    job_valid = 1'b0;
    res_ready = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic send(input logic [3:0] n, input logic [3:0] tag);
    int guard;
    job_n = n;
    job_tag = tag;
    job_valid = 1'b1;
    guard = 0;
    while (!job_ready && guard < 400) begin
      tick();
      guard++;
    end
    check("job_ready_wait", 64'(job_ready), 64'd1);
    tick();
    job_valid = 1'b0;
  endtask

  task automatic pop_check(input logic [31:0] val, input logic err, input logic [3:0] tag);
    int guard;
    guard = 0;
    while (!res_valid && guard < 400) begin
      tick();
      guard++;
    end
    check("res_valid_wait", 64'(res_valid), 64'd1);
    check("res_data", 64'(res_data), 64'(val));
    check("res_err", 64'(res_err), 64'(err));
    check("res_tag", 64'(res_tag), 64'(tag));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int guard;
    int pend;
    for (int u = 0; u < 4; u++) begin
      u_n[u] = 4'd0;
      u_cnt[u] = 0;
      u_lat[u] = 3;
    end
    u_done = 4'd0;
    for (int t = 0; t < 16; t++) begin
      exp_pend[t] = 1'b0;
      exp_val[t] = 32'd0;
      exp_err[t] = 1'b0;
    end

    // Reset values
    tick();
    check("rst_job_ready", 64'(job_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_we", 64'(fact_we), 64'd0);
    check("rst_addr", 64'(fact_addr), 64'd0);
    check("rst_wdata_lo", fact_wdata[63:0], 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res", {27'd0, res_tag, res_err, res_data}, 64'd0);
    rst = 1'b1;
    tick();

    // Single job N=5 tag 3
    send(4'd5, 4'd3);
    check("t1_we_n", 64'(fact_we), 64'b0001);
    check("t1_addr_n", 64'(fact_addr), 64'd0);
    check("t1_wdata_n", 64'(fact_wdata[31:0]), 64'd5);
    tick();
    check("t1_we_go", 64'(fact_we), 64'b0001);
    check("t1_addr_go", 64'(fact_addr), 64'd1);
    check("t1_wdata_go", 64'(fact_wdata[31:0]), 64'd1);
    tick();
    check("t1_busy", 64'(busy), 64'b0001);
    pop_check(32'h78, 1'b0, 4'd3);
    check("t1_busy_clr", 64'(busy), 64'd0);

    // Four back-to-back jobs fill every unit in order
    reset_dut();
    for (int u = 0; u < 4; u++) u_lat[u] = 50;
    send(4'd1, 4'd1);
    check("t2_unit0", 64'(fact_we), 64'b0001);
    send(4'd4, 4'd2);
    check("t2_unit1", 64'(fact_we), 64'b0010);
    send(4'd10, 4'd3);
    check("t2_unit2", 64'(fact_we), 64'b0100);
    send(4'd12, 4'd4);
    check("t2_unit3", 64'(fact_we), 64'b1000);
    tick();
    tick();
    check("t2_all_busy", 64'(busy), 64'hF);
    job_valid = 1'b1;
    check("t2_fifth_blocked", 64'(job_ready), 64'd0);
    send(4'd2, 4'd5);
    check("t2_fifth_unit0", 64'(fact_we), 64'b0001);
    pop_check(32'd1, 1'b0, 4'd1);
    pop_check(32'h18, 1'b0, 4'd2);
    pop_check(32'h375F00, 1'b0, 4'd3);
    pop_check(32'h1C8CFC00, 1'b0, 4'd4);
    pop_check(32'd2, 1'b0, 4'd5);

    // Out-of-range N reports err
    reset_dut();
    for (int u = 0; u < 4; u++) u_lat[u] = 4;
    send(4'd13, 4'd7);
    pop_check(32'd0, 1'b1, 4'd7);
    send(4'd3, 4'd8);
    pop_check(32'd6, 1'b0, 4'd8);

    // Collect wins over a simultaneous job offer
    reset_dut();
    u_lat[0] = 6;
    send(4'd4, 4'd9);
    tick();
    tick();
    guard = 0;
    while (!fact_done[0] && guard < 100) begin
      tick();
      guard++;
    end
    check("t4_done_seen", 64'(fact_done[0]), 64'd1);
    job_n = 4'd2;
    job_tag = 4'd10;
    job_valid = 1'b1;
    check("t4_ready_T", 64'(job_ready), 64'd0);
    tick();
    check("t4_rd_res", 64'(fact_addr), 64'h03);
    check("t4_ready_T1", 64'(job_ready), 64'd0);
    tick();
    check("t4_rd_stat", 64'(fact_addr), 64'h02);
    tick();
    check("t4_ready_T3", 64'(job_ready), 64'd1);
    tick();
    job_valid = 1'b0;
    check("t4_disp_unit1", 64'(fact_we), 64'b0010);
    pop_check(32'd24, 1'b0, 4'd9);
    pop_check(32'd2, 1'b0, 4'd10);

    // Full FIFO blocks collection until one pop
    reset_dut();
    for (int u = 0; u < 4; u++) u_lat[u] = 5;
    send(4'd1, 4'd1);
    send(4'd2, 4'd2);
    send(4'd3, 4'd3);
    send(4'd4, 4'd4);
    guard = 0;
    while (busy != 4'd0 && guard < 200) begin
      tick();
      guard++;
    end
    check("t5_drained", 64'(busy), 64'd0);
    send(4'd5, 4'd5);
    repeat (20) tick();
    check("t5_busy_held", 64'(busy), 64'b0001);
    check("t5_no_read", 64'(fact_addr), 64'd0);
    check("t5_head_tag", 64'(res_tag), 64'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
    check("t5_rd_res", 64'(fact_addr), 64'h03);
    tick();
    check("t5_rd_stat", 64'(fact_addr), 64'h02);
    tick();
    check("t5_busy_clr", 64'(busy), 64'd0);
    pop_check(32'd2, 1'b0, 4'd2);
    pop_check(32'd6, 1'b0, 4'd3);
    pop_check(32'd24, 1'b0, 4'd4);
    pop_check(32'd120, 1'b0, 4'd5);

    // Asynchronous reset in the middle of WR_GO
    reset_dut();
    send(4'd6, 4'd11);
    tick();
    check("t6_in_go", 64'(fact_we), 64'b0001);
    #2;
    rst = 1'b0;
    #1;
    check("t6_we", 64'(fact_we), 64'd0);
    check("t6_addr", 64'(fact_addr), 64'd0);
    check("t6_wdata", fact_wdata[63:0], 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_ready", 64'(job_ready), 64'd0);
    check("t6_res_valid", 64'(res_valid), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    u_lat[0] = 3;
    send(4'd3, 4'd12);
    check("t6_restart_unit0", 64'(fact_we), 64'b0001);
    pop_check(32'd6, 1'b0, 4'd12);

    // Randomized traffic against the tag scoreboard
    reset_dut();
    for (int j = 0; j < 60; j++) begin
      for (int u = 0; u < 4; u++) u_lat[u] = $urandom_range(1, 25);
      job_n = 4'($urandom_range(0, 15));
      job_tag = 4'(j);
      job_valid = 1'b1;
      guard = 0;
      while (!job_ready && guard < 400) begin
        res_ready = 1'($urandom_range(0, 1));
        tick();
        guard++;
      end
      check("rand_ready", 64'(job_ready), 64'd1);
      tick();
      job_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        res_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    res_ready = 1'b1;
    guard = 0;
    while ((busy != 4'd0 || res_valid) && guard < 2000) begin
      tick();
      guard++;
    end
    res_ready = 1'b0;
    check("rand_busy_end", 64'(busy), 64'd0);
    check("rand_empty_end", 64'(res_valid), 64'd0);
    pend = 0;
    for (int t = 0; t < 16; t++) pend += int'(exp_pend[t]);
    check("rand_all_returned", 64'(pend), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
